// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the MM:SS stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FROZEN,
    PAUSE
  } sw_state_t;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;
  localparam logic [3:0] UNITS_MAX    = 4'd9;

  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button pulses in, BCD digits and status out, between the controller and its neighbours.
interface stopwatch_ctrl_if;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;
  logic [3:0] d;
  logic       running;
  logic       frozen;

  modport master (
    output start_stop, lap, clear,
    input  a, b, c, d, running, frozen
  );

  modport slave (
    input  start_stop, lap, clear,
    output a, b, c, d, running, frozen
  );
endinterface

// File: rtl/stopwatch_ctrl_bcd_digit_ctr.sv
// One BCD digit counting 0..MAX; carry is high on the increment that wraps it.
module bcd_digit_ctr
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = UNITS_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic [3:0] q_next,
  output logic       carry
);

  assign carry = inc && (q == MAX);

  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = '0;
    end else if (inc) begin
      q_next = (q == MAX) ? '0 : q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch: prescaler, IDLE/RUN/FROZEN/PAUSE control, lap latch, registered digit outputs.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave bus
);

  localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  sw_state_t     state, state_next;
  logic [PW-1:0] presc;
  logic          counting, tick, load_lap;
  bcd_time_t     live, live_next, lap_q, lap_next;
  logic          s0_carry, s1_carry, m0_carry, wrap_unused;

  assign counting = (state == RUN) || (state == FROZEN);
  assign tick     = counting && (presc == PRESC_LAST);

  bcd_digit_ctr #(.MAX(UNITS_MAX)) u_s0 (
    .clk(clk), .rst(rst), .clr(bus.clear), .inc(tick),
    .q(live.s0), .q_next(live_next.s0), .carry(s0_carry)
  );
  bcd_digit_ctr #(.MAX(SEC_TENS_MAX)) u_s1 (
    .clk(clk), .rst(rst), .clr(bus.clear), .inc(s0_carry),
    .q(live.s1), .q_next(live_next.s1), .carry(s1_carry)
  );
  bcd_digit_ctr #(.MAX(UNITS_MAX)) u_m0 (
    .clk(clk), .rst(rst), .clr(bus.clear), .inc(s1_carry),
    .q(live.m0), .q_next(live_next.m0), .carry(m0_carry)
  );
  bcd_digit_ctr #(.MAX(MIN_TENS_MAX)) u_m1 (
    .clk(clk), .rst(rst), .clr(bus.clear), .inc(m0_carry),
    .q(live.m1), .q_next(live_next.m1), .carry(wrap_unused)
  );

  always_comb begin
    state_next = state;
    load_lap   = 1'b0;
    if (bus.clear) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:   if (bus.start_stop) state_next = RUN;
        RUN: begin
          if (bus.start_stop) begin
            state_next = PAUSE;
          end else if (bus.lap) begin
            state_next = FROZEN;
            load_lap   = 1'b1;
          end
        end
        FROZEN: begin
          if (bus.start_stop)  state_next = PAUSE;
          else if (bus.lap)    state_next = RUN;
        end
        PAUSE:  if (bus.start_stop) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Latch takes the registered (pre-increment) count even on a tick cycle.
  assign lap_next = load_lap ? live : lap_q;

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      presc <= '0;
    end else if (counting) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  // Outputs are computed from next-state values so they stay fully registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                      <= IDLE;
      lap_q                      <= '0;
      {bus.a, bus.b, bus.c, bus.d} <= '0;
      bus.running                <= 1'b0;
      bus.frozen                 <= 1'b0;
    end else begin
      state                      <= state_next;
      lap_q                      <= lap_next;
      {bus.a, bus.b, bus.c, bus.d} <= (state_next == FROZEN) ? lap_next : live_next;
      bus.running                <= (state_next == RUN) || (state_next == FROZEN);
      bus.frozen                 <= (state_next == FROZEN);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with TICK_DIV=4: expectations keyed to clock edges.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(sw_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    string       name;
    logic [15:0] dig;
    logic        run;
    logic        frz;
  } exp_t;

  exp_t sb[$];

  // t is the edge count after which the outputs must show the expected value.
  function automatic void expect_at(int t, string name, logic [15:0] dig, logic run, logic frz);
    exp_t e;
    if (t <= cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL sched %s: check edge %0d not after current edge %0d", name, t, cyc);
    end else begin
      e.t = t; e.name = name; e.dig = dig; e.run = run; e.frz = frz;
      sb.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    logic [15:0] got;
    got = {sw_if.a, sw_if.b, sw_if.c, sw_if.d};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].t == cyc) begin
        n_checks++;
        if (got !== sb[i].dig || sw_if.running !== sb[i].run || sw_if.frozen !== sb[i].frz) begin
          n_fail++;
          $display("FAIL %s @edge %0d: got %h run=%b frz=%b, want %h run=%b frz=%b",
                   sb[i].name, cyc, got, sw_if.running, sw_if.frozen,
                   sb[i].dig, sb[i].run, sb[i].frz);
        end
        sb.delete(i);
      end
    end
  end

  // Drive the given pulses so they are sampled at edge e.
  task automatic pulse_at(int e, bit ss, bit l, bit cl, bit r);
    if (cyc > e - 1) begin
      n_checks++;
      n_fail++;
      $display("FAIL sched pulse for edge %0d issued late at edge %0d", e, cyc);
    end
    while (cyc < e - 1) @(negedge clk);
    sw_if.start_stop = ss;
    sw_if.lap        = l;
    sw_if.clear      = cl;
    rst              = r;
    @(negedge clk);
    sw_if.start_stop = 1'b0;
    sw_if.lap        = 1'b0;
    sw_if.clear      = 1'b0;
    rst              = 1'b0;
  endtask

  initial begin
    int s, t0, l, p, r, c, b, x;
    rst              = 1'b1;
    sw_if.start_stop = 1'b0;
    sw_if.lap        = 1'b0;
    sw_if.clear      = 1'b0;
    repeat (3) @(negedge clk);
    expect_at(cyc + 1, "reset", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    s = cyc + 2;
    expect_at(s,      "start",        16'h0000, 1'b1, 1'b0);
    expect_at(s + 3,  "pre_tick",     16'h0000, 1'b1, 1'b0);
    expect_at(s + 4,  "first_tick",   16'h0001, 1'b1, 1'b0);
    expect_at(s + 40, "ten_sec",      16'h0010, 1'b1, 1'b0);
    t0 = s + 14400;
    expect_at(t0 - 8, "at_5958",      16'h5958, 1'b1, 1'b0);
    expect_at(t0 - 5, "hold_5958",    16'h5958, 1'b1, 1'b0);
    expect_at(t0 - 4, "at_5959",      16'h5959, 1'b1, 1'b0);
    expect_at(t0,     "wrap_0000",    16'h0000, 1'b1, 1'b0);
    pulse_at(s, 1'b1, 1'b0, 1'b0, 1'b0);

    l = t0 + 13;
    expect_at(l,      "lap_freeze",   16'h0003, 1'b1, 1'b1);
    expect_at(l + 5,  "frozen_hold",  16'h0003, 1'b1, 1'b1);
    expect_at(l + 11, "frozen_hold2", 16'h0003, 1'b1, 1'b1);
    expect_at(l + 12, "lap_release",  16'h0006, 1'b1, 1'b0);
    expect_at(t0 + 28, "live_again",  16'h0007, 1'b1, 1'b0);
    pulse_at(l, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_at(l + 12, 1'b0, 1'b1, 1'b0, 1'b0);

    p = t0 + 34;
    r = p + 20;
    expect_at(p,      "pause",        16'h0008, 1'b0, 1'b0);
    expect_at(p + 10, "pause_hold",   16'h0008, 1'b0, 1'b0);
    expect_at(r - 1,  "pause_end",    16'h0008, 1'b0, 1'b0);
    expect_at(r,      "resume",       16'h0008, 1'b1, 1'b0);
    expect_at(r + 1,  "resume_wait",  16'h0008, 1'b1, 1'b0);
    expect_at(r + 2,  "resume_tick",  16'h0009, 1'b1, 1'b0);
    pulse_at(p, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_at(p + 5, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_at(r, 1'b1, 1'b0, 1'b0, 1'b0);

    c = t0 + 64;
    expect_at(c,      "clear_prio",   16'h0000, 1'b0, 1'b0);
    expect_at(c + 8,  "idle_hold",    16'h0000, 1'b0, 1'b0);
    pulse_at(c, 1'b1, 1'b0, 1'b1, 1'b0);

    b = c + 10;
    x = b + 33;
    expect_at(b + 8,  "lap_on_tick",  16'h0001, 1'b1, 1'b1);
    expect_at(b + 10, "lap_tick_hold",16'h0001, 1'b1, 1'b1);
    expect_at(b + 16, "pause_on_tick",16'h0004, 1'b0, 1'b0);
    expect_at(b + 20, "pause2_hold",  16'h0004, 1'b0, 1'b0);
    expect_at(b + 22, "resume2",      16'h0004, 1'b1, 1'b0);
    expect_at(b + 25, "resume2_wait", 16'h0004, 1'b1, 1'b0);
    expect_at(b + 26, "resume2_tick", 16'h0005, 1'b1, 1'b0);
    expect_at(b + 27, "lap2",         16'h0005, 1'b1, 1'b1);
    expect_at(b + 32, "lap2_hold",    16'h0005, 1'b1, 1'b1);
    expect_at(x,      "rst_frozen",   16'h0000, 1'b0, 1'b0);
    expect_at(x + 1,  "idle_lap_ign", 16'h0000, 1'b0, 1'b0);
    expect_at(x + 3,  "restart",      16'h0000, 1'b1, 1'b0);
    expect_at(x + 6,  "restart_wait", 16'h0000, 1'b1, 1'b0);
    expect_at(x + 7,  "restart_tick", 16'h0001, 1'b1, 1'b0);
    pulse_at(b, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_at(b + 8, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_at(b + 16, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_at(b + 22, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_at(b + 27, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_at(x, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse_at(x + 1, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_at(x + 3, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: never checked, due at edge %0d, now edge %0d", sb[0].name, sb[0].t, cyc);
      sb.delete(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
